// File: rtl/pipelined_adder.sv
// Pipelined ripple-chunk adder with valid/ready handshake.
// The WIDTH-bit add is cut into STAGES chunks of WIDTH/STAGES bits; each stage
// adds one chunk plus the registered carry from the previous stage, and the
// not-yet-added operand chunks plus the finished sum chunks ride along with
// their transaction.  The whole pipe advances together or holds together.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake for a, b, cin
//   a, b, cin           operands and carry-in
//   out_valid/out_ready output handshake for sum, carry, ovf
//   sum                 (a + b + cin) mod 2^WIDTH
//   carry               carry out of the MSB
//   ovf                 carry (SIGNED=0) or two's-complement overflow (SIGNED=1)
module pipelined_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned CW = WIDTH / STAGES;

    // Whole-pipe advance: output slot is either empty or being drained.
    logic advance;
    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned RW = WIDTH - k * CW;   // operand bits still to add
        localparam int unsigned DW = (k + 1) * CW;     // sum bits complete after this stage

        logic [RW-1:0] a_in;
        logic [RW-1:0] b_in;
        logic          c_in;
        logic          v_in;
        logic [CW:0]   add;
        logic [DW-1:0] s_new;

        // Stage source: module inputs for stage 0, previous stage register otherwise.
        if (k == 0) begin : g_src
            assign a_in  = a;
            assign b_in  = b;
            assign c_in  = cin;
            assign v_in  = in_valid;
            assign s_new = add[CW-1:0];
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_reg.a_q;
            assign b_in  = g_stage[k-1].g_reg.b_q;
            assign c_in  = g_stage[k-1].g_reg.c_q;
            assign v_in  = g_stage[k-1].g_reg.v_q;
            assign s_new = {add[CW-1:0], g_stage[k-1].g_reg.s_q};
        end

        // One chunk add: lowest remaining operand chunk plus incoming carry.
        assign add = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

        if (k < STAGES - 1) begin : g_reg
            logic [RW-CW-1:0] a_q;
            logic [RW-CW-1:0] b_q;
            logic [DW-1:0]    s_q;
            logic             c_q;
            logic             v_q;

            // Intermediate stage register: drop consumed chunk, keep the rest.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (advance) begin
                    a_q <= a_in[RW-1:CW];
                    b_q <= b_in[RW-1:CW];
                    s_q <= s_new;
                    c_q <= add[CW];
                    v_q <= v_in;
                end
            end
        end else begin : g_out
            logic ovf_new;

            // Carry into the MSB equals a_msb ^ b_msb ^ sum_msb; xor with carry-out
            // gives signed overflow without a separate partial add.
            assign ovf_new = (SIGNED != 0) ?
                             (a_in[RW-1] ^ b_in[RW-1] ^ add[CW-1] ^ add[CW]) :
                             add[CW];

            // Output register: final chunk, carry and overflow.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum       <= '0;
                    carry     <= 1'b0;
                    ovf       <= 1'b0;
                    out_valid <= 1'b0;
                end else if (advance) begin
                    sum       <= s_new;
                    carry     <= add[CW];
                    ovf       <= ovf_new;
                    out_valid <= v_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: several adder configurations share one stimulus stream;
// each has its own expected-result FIFO filled from an arithmetic reference model.
module tb_pipelined_adder;

    localparam int ND = 5;
    localparam int CFG_W [ND] = '{8, 8, 1, 8, 8};
    localparam int CFG_S [ND] = '{2, 2, 1, 8, 1};
    localparam int CFG_G [ND] = '{0, 1, 0, 1, 1};

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;

    logic [ND-1:0][7:0] o_sum;
    logic [ND-1:0]      o_car;
    logic [ND-1:0]      o_ovf;
    logic [ND-1:0]      o_vld;
    logic [ND-1:0]      o_rdy;

    exp_t mem [ND][16];
    int   wr [ND];
    int   rd [ND];
    int   cnt [ND];
    int   cyc;
    int   n_checks;
    int   n_errors;
    bit   lat_chk;
    bit   expect_stall;

    always #5 clk = ~clk;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        localparam int unsigned W = CFG_W[d];
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         v;
        logic         r;

        pipelined_adder #(
            .WIDTH (W),
            .STAGES(CFG_S[d]),
            .SIGNED(CFG_G[d])
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (r),
            .a        (a[W-1:0]),
            .b        (b[W-1:0]),
            .cin      (cin),
            .out_valid(v),
            .out_ready(out_ready),
            .sum      (s),
            .carry    (c),
            .ovf      (o)
        );

        assign o_sum[d] = 8'(s);
        assign o_car[d] = c;
        assign o_ovf[d] = o;
        assign o_vld[d] = v;
        assign o_rdy[d] = r;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic exp_t ref_add(int w, int sg, logic [7:0] x, logic [7:0] y, logic ci);
        exp_t e;
        int   m  = (1 << w) - 1;
        int   ux = int'(x) & m;
        int   uy = int'(y) & m;
        int   full = ux + uy + int'(ci);
        int   sx;
        int   sy;
        int   r;
        e.s = 8'(full & m);
        e.c = (full >> w) != 0;
        if (sg != 0) begin
            sx = (ux >= (1 << (w - 1))) ? ux - (1 << w) : ux;
            sy = (uy >= (1 << (w - 1))) ? uy - (1 << w) : uy;
            r  = sx + sy + int'(ci);
            e.o = (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
        end else begin
            e.o = e.c;
        end
        e.cyc = 0;
        return e;
    endfunction

    // One clock: sample settled outputs, score transfers, advance to next negedge.
    task automatic step();
        exp_t e;
        #1;
        for (int d = 0; d < ND; d++) begin
            if (o_vld[d]) begin
                if (cnt[d] == 0) begin
                    check_eq($sformatf("d%0d_spurious_valid", d), 32'(o_vld[d]), 32'd0);
                end else begin
                    e = mem[d][rd[d]];
                    check_eq($sformatf("d%0d_sum", d), 32'(o_sum[d]), 32'(e.s));
                    check_eq($sformatf("d%0d_carry", d), 32'(o_car[d]), 32'(e.c));
                    check_eq($sformatf("d%0d_ovf", d), 32'(o_ovf[d]), 32'(e.o));
                    if (lat_chk)
                        check_eq($sformatf("d%0d_latency", d), 32'(cyc - e.cyc), 32'(CFG_S[d]));
                    if (out_ready) begin
                        rd[d]  = (rd[d] + 1) % 16;
                        cnt[d] = cnt[d] - 1;
                    end
                end
            end
            if (out_ready)
                check_eq($sformatf("d%0d_in_ready", d), 32'(o_rdy[d]), 32'd1);
            if (expect_stall)
                check_eq($sformatf("d%0d_in_ready_stall", d), 32'(o_rdy[d]), 32'd0);
            if (in_valid && o_rdy[d]) begin
                e = ref_add(CFG_W[d], CFG_G[d], a, b, cin);
                e.cyc = cyc;
                mem[d][wr[d]] = e;
                wr[d]  = (wr[d] + 1) % 16;
                cnt[d] = cnt[d] + 1;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic vv);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = vv;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("d%0d_%s_out_valid", d, tag), 32'(o_vld[d]), 32'd0);
            check_eq($sformatf("d%0d_%s_sum", d, tag), 32'(o_sum[d]), 32'd0);
            check_eq($sformatf("d%0d_%s_carry", d, tag), 32'(o_car[d]), 32'd0);
            check_eq($sformatf("d%0d_%s_ovf", d, tag), 32'(o_ovf[d]), 32'd0);
            check_eq($sformatf("d%0d_%s_in_ready", d, tag), 32'(o_rdy[d]), 32'd1);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < ND; d++) begin
            wr[d]  = 0;
            rd[d]  = 0;
            cnt[d] = 0;
        end
    endtask

    localparam logic [17:0] SEQ [12] = '{
        {8'hFF, 8'h01, 1'b0, 1'b1},
        {8'h7F, 8'h01, 1'b0, 1'b1},
        {8'h80, 8'hFF, 1'b0, 1'b1},
        {8'h10, 8'h20, 1'b0, 1'b1},
        {8'h0F, 8'h01, 1'b1, 1'b1},
        {8'hF0, 8'h10, 1'b0, 1'b1},
        {8'hAA, 8'h55, 1'b0, 1'b1},
        {8'h00, 8'h00, 1'b0, 1'b0},
        {8'h00, 8'h00, 1'b0, 1'b1},
        {8'h01, 8'h00, 1'b0, 1'b1},
        {8'h00, 8'h01, 1'b0, 1'b1},
        {8'h01, 8'h01, 1'b0, 1'b1}
    };

    initial begin
        logic [17:0] v;
        n_checks     = 0;
        n_errors     = 0;
        cyc          = 0;
        lat_chk      = 1'b0;
        expect_stall = 1'b0;
        clear_model();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Directed back-to-back operands, a bubble, half-adder combos; no stalls.
        lat_chk = 1'b1;
        for (int i = 0; i < 12; i++) begin
            v = SEQ[i];
            drive(v[17:10], v[9:2], v[1], v[0]);
        end
        for (int i = 0; i < 10; i++) drive(8'h00, 8'h00, 1'b0, 1'b0);
        lat_chk = 1'b0;

        // Fill the pipe, stall downstream for 3 cycles, then release.
        for (int i = 0; i < 10; i++) drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        out_ready    = 1'b0;
        expect_stall = 1'b1;
        for (int i = 0; i < 3; i++) drive(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        expect_stall = 1'b0;
        out_ready    = 1'b1;
        for (int i = 0; i < 12; i++) drive(8'h00, 8'h00, 1'b0, 1'b0);

        // Reset asserted between edges with transactions in flight.
        drive(8'h12, 8'h34, 1'b0, 1'b1);
        drive(8'h56, 8'h78, 1'b1, 1'b1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        lat_chk = 1'b1;
        drive(8'h01, 8'h02, 1'b0, 1'b1);
        drive(8'h80, 8'h80, 1'b1, 1'b1);
        drive(8'h7F, 8'h7F, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive(8'h00, 8'h00, 1'b0, 1'b0);
        lat_chk = 1'b0;

        // Random traffic with random back-pressure and bubbles.
        for (int i = 0; i < 12000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        // Drain and confirm nothing was lost.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) drive(8'h00, 8'h00, 1'b0, 1'b0);
        for (int d = 0; d < ND; d++)
            check_eq($sformatf("d%0d_drain_left", d), 32'(cnt[d]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
